// File: rtl/foobar_rx.sv
// Receive end of the foo/bar pulse interface: assembles MSB-first words,
// keeps symbol/word tallies and flags illegal symbols and stalled frames.
module foobar_rx #(
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             foo,
   input  logic             bar,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             err,
   output logic [7:0]       count_foo,
   output logic [7:0]       count_bar,
   output logic [7:0]       word_count
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic {IDLE, RECV} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx, data_nx;
   logic [BW-1:0]    bits, bits_nx;
   logic [TW-1:0]    timer, timer_nx;
   logic             valid_nx, err_nx;
   logic [7:0]       cf_nx, cb_nx, wc_nx;
   logic             legal, illegal;

   assign legal   = foo ^ bar;
   assign illegal = foo & bar;

   // First symbol enters at the LSB and is shifted up; after WIDTH symbols it
   // sits in bit[WIDTH-1], same result as loading the MSB directly.
   always_comb begin
      state_nx = state;
      sreg_nx  = sreg;
      bits_nx  = bits;
      timer_nx = timer;
      data_nx  = data;
      valid_nx = 1'b0;
      err_nx   = 1'b0;
      cf_nx    = count_foo;
      cb_nx    = count_bar;
      wc_nx    = word_count;
      if (en) begin
         if (illegal) begin
            state_nx = IDLE;
            sreg_nx  = '0;
            bits_nx  = '0;
            timer_nx = '0;
            err_nx   = 1'b1;
         end else if (legal) begin
            if (foo) cf_nx = count_foo + 8'd1;
            else     cb_nx = count_bar + 8'd1;
            timer_nx = '0;
            if (state == IDLE) begin
               sreg_nx  = {{(WIDTH-1){1'b0}}, bar};
               bits_nx  = BW'(1);
               state_nx = RECV;
            end else if (bits == BW'(WIDTH - 1)) begin
               data_nx  = {sreg[WIDTH-2:0], bar};
               valid_nx = 1'b1;
               wc_nx    = word_count + 8'd1;
               sreg_nx  = '0;
               bits_nx  = '0;
               state_nx = IDLE;
            end else begin
               sreg_nx = {sreg[WIDTH-2:0], bar};
               bits_nx = bits + BW'(1);
            end
         end else if (state == RECV) begin
            if (timer == TW'(TIMEOUT - 1)) begin
               state_nx = IDLE;
               sreg_nx  = '0;
               bits_nx  = '0;
               timer_nx = '0;
               err_nx   = 1'b1;
            end else begin
               timer_nx = timer + TW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sreg       <= '0;
         bits       <= '0;
         timer      <= '0;
         data       <= '0;
         valid      <= 1'b0;
         err        <= 1'b0;
         count_foo  <= '0;
         count_bar  <= '0;
         word_count <= '0;
      end else begin
         state      <= state_nx;
         sreg       <= sreg_nx;
         bits       <= bits_nx;
         timer      <= timer_nx;
         data       <= data_nx;
         valid      <= valid_nx;
         err        <= err_nx;
         count_foo  <= cf_nx;
         count_bar  <= cb_nx;
         word_count <= wc_nx;
      end
   end

endmodule

// File: tb/tb_foobar_rx.sv
// Directed plus randomized bench for foobar_rx, checked every cycle against a
// queue-based symbol model.
module tb_foobar_rx;

   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;

   logic             clk = 1'b0;
   logic             rst_n, en, foo, bar;
   logic [WIDTH-1:0] data;
   logic             valid, err;
   logic [7:0]       count_foo, count_bar, word_count;

   always #5 clk = ~clk;

   foobar_rx #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .foo(foo), .bar(bar),
      .data(data), .valid(valid), .err(err),
      .count_foo(count_foo), .count_bar(count_bar), .word_count(word_count)
   );

   int compared   = 0;
   int mismatched = 0;

   // Reference model: partial word as a queue of received bits.
   int         m_bits[$];
   int         m_idle;
   int         m_cf, m_cb, m_wc;
   logic [7:0] m_data;
   logic       m_valid, m_err;

   function automatic void model_reset();
      m_bits.delete();
      m_idle = 0; m_cf = 0; m_cb = 0; m_wc = 0;
      m_data = '0; m_valid = 1'b0; m_err = 1'b0;
   endfunction

   function automatic void model_step(input bit e, input bit f, input bit b);
      int d;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!e) return;
      if (f && b) begin
         m_bits.delete();
         m_idle = 0;
         m_err  = 1'b1;
      end else if (f || b) begin
         m_bits.push_back(b ? 1 : 0);
         if (b) m_cb = (m_cb + 1) % 256;
         else   m_cf = (m_cf + 1) % 256;
         m_idle = 0;
         if (m_bits.size() == WIDTH) begin
            d = 0;
            foreach (m_bits[i]) d = d * 2 + m_bits[i];
            m_data  = d[7:0];
            m_wc    = (m_wc + 1) % 256;
            m_valid = 1'b1;
            m_bits.delete();
         end
      end else if (m_bits.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT) begin
            m_bits.delete();
            m_idle = 0;
            m_err  = 1'b1;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("data", 32'(data), 32'(m_data));
      chk("valid", 32'(valid), 32'(m_valid));
      chk("err", 32'(err), 32'(m_err));
      chk("count_foo", 32'(count_foo), 32'(m_cf));
      chk("count_bar", 32'(count_bar), 32'(m_cb));
      chk("word_count", 32'(word_count), 32'(m_wc));
   endtask

   task automatic tick(input bit e, input bit f, input bit b);
      en = e; foo = f; bar = b;
      @(posedge clk);
      model_step(e, f, b);
      #1;
      check_all();
   endtask

   task automatic send_word(input logic [7:0] w, input int gap);
      for (int i = WIDTH - 1; i >= 0; i--) begin
         tick(1'b1, !w[i], w[i]);
         if (i > 0) repeat (gap) tick(1'b1, 1'b0, 1'b0);
      end
   endtask

   initial begin
      int r, s;
      rst_n = 1'b0; en = 1'b0; foo = 1'b0; bar = 1'b0;
      model_reset();
      #1;
      check_all();
      #12;
      @(negedge clk) rst_n = 1'b1;

      // 1: A3 streamed without gaps
      send_word(8'hA3, 0);
      chk("t1_data", 32'(data), 32'h A3);
      chk("t1_valid", 32'(valid), 32'd1);
      chk("t1_cnt", {8'(word_count), 8'(count_foo), 8'(count_bar)}, {8'd1, 8'd4, 8'd4});

      // 2: back-to-back FF/00, then 3C with 15-cycle gaps
      send_word(8'hFF, 0);
      send_word(8'h00, 0);
      send_word(8'h3C, TIMEOUT - 1);
      chk("t2_data", 32'(data), 32'h3C);

      // 3: illegal symbol on 3rd bit, then a clean 5A
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b1);
      chk("t3_err", 32'(err), 32'd1);
      send_word(8'h5A, 0);
      chk("t3_data", 32'(data), 32'h5A);

      // 4: three symbols then a stall to timeout
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      repeat (TIMEOUT - 1) tick(1'b1, 1'b0, 1'b0);
      chk("t4_err_early", 32'(err), 32'd0);
      tick(1'b1, 1'b0, 1'b0);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_wc", 32'(word_count), 32'd5);

      // 5: en low mid-word while foo toggles
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) tick(1'b0, i[0], 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      chk("t5_data", 32'(data), 32'hB4);

      // 6: async reset between edges mid-word, then 32 x FF
      tick(1'b1, 1'b0, 1'b1);
      tick(1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk) rst_n = 1'b1;
      repeat (32) send_word(8'hFF, 0);
      chk("t6_cbar_wrap", 32'(count_bar), 32'd0);
      chk("t6_wc", 32'(word_count), 32'd32);

      // randomized symbols, enables and stalls
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 99);
         s = $urandom_range(0, 9);
         if ($urandom_range(0, 30) == 0)
            repeat (TIMEOUT + 2) tick(1'b1, 1'b0, 1'b0);
         else
            tick(r < 90, (s == 0) || (s >= 1 && s <= 3), (s == 0) || (s >= 4 && s <= 6));
         chk("excl", 32'(valid & err), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
